execute_stage: RTL

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// EX stage of a 5-stage RV32 pipeline: operand forwarding, ALU, branch resolution and EX/MEM register.
// Optional signed set-less-than on ALUControlE=101 is enabled by defining EXEC_SLT_EN.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [4:0]  RD_E,
    input  logic [31:0] PCE,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ResultW,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] WriteDataM,
    output logic [31:0] ALU_ResultM
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    logic        r_reg_write;
    logic        r_mem_write;
    logic        r_result_src;
    logic [4:0]  r_rd;
    logic [31:0] r_write_data;
    logic [31:0] r_alu_result;

    logic [31:0] w_src_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_src_b;
    logic [31:0] w_alu_result;
    logic        w_zero;

    // Select 10 reads the EX/MEM register, i.e. the previous instruction's result.
    always_comb begin
        w_src_a = RD1_E;
        unique case (ForwardAE)
            2'b01:   w_src_a = ResultW;
            2'b10:   w_src_a = r_alu_result;
            default: w_src_a = RD1_E;
        endcase
    end

    always_comb begin
        w_fwd_b = RD2_E;
        unique case (ForwardBE)
            2'b01:   w_fwd_b = ResultW;
            2'b10:   w_fwd_b = r_alu_result;
            default: w_fwd_b = RD2_E;
        endcase
    end

    assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;

    always_comb begin
        w_alu_result = '0;
        case (ALUControlE)
            ALU_ADD: w_alu_result = w_src_a + w_src_b;
            ALU_SUB: w_alu_result = w_src_a - w_src_b;
            ALU_AND: w_alu_result = w_src_a & w_src_b;
            ALU_OR:  w_alu_result = w_src_a | w_src_b;
`ifdef EXEC_SLT_EN
            ALU_SLT: w_alu_result = {31'd0, ($signed(w_src_a) < $signed(w_src_b))};
`endif
            default: w_alu_result = '0;
        endcase
    end

    assign w_zero    = (w_alu_result == '0);
    assign PCSrcE    = BranchE & w_zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= 1'b0;
            r_rd         <= '0;
            r_write_data <= '0;
            r_alu_result <= '0;
        end else begin
            r_reg_write  <= RegWriteE;
            r_mem_write  <= MemWriteE;
            r_result_src <= ResultSrcE;
            r_rd         <= RD_E;
            r_write_data <= w_fwd_b;
            r_alu_result <= w_alu_result;
        end
    end

    assign RegWriteM   = r_reg_write;
    assign MemWriteM   = r_mem_write;
    assign ResultSrcM  = r_result_src;
    assign RD_M        = r_rd;
    assign WriteDataM  = r_write_data;
    assign ALU_ResultM = r_alu_result;

endmodule
